hazard_scoreboard: RTL and testbench

//  Parametrised scoreboard-based hazard/stall unit for the in-order pipeline; sits between fetch and decode.
//  Per-register countdown counters track pending writes; per-stage compare chains are replaced.

---
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard-based issue/stall unit between fetch and decode.
// Each architectural register has a countdown of cycles until its pending
// write becomes readable. A control op blocks all issue for CTRL_LAT cycles.
// When an instruction cannot issue, a NOP bubble is sent to decode instead.
// Optional feature macro: HAZ_FWD_EN. When it is defined, EX/MEM forwarding is
// assumed, and only a load result consumed in the very next cycle interlocks.
// The default build (macro undefined) is a full interlock.
module hazard_scoreboard #(
   parameter int                NUM_REGS = 8,
   parameter int                REG_W    = 3,
   parameter int                WR_LAT   = 3,
   parameter int                CTRL_LAT = 4,
   parameter int                INST_W   = 16,
   parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   input  logic [INST_W-1:0]   in_inst_i,
   input  logic                rs_en_i,
   input  logic [REG_W-1:0]    rs_idx_i,
   input  logic                rt_en_i,
   input  logic [REG_W-1:0]    rt_idx_i,
   input  logic                wr_en_i,
   input  logic [REG_W-1:0]    wr_idx_i,
   input  logic                wr_load_i,
   input  logic                is_ctrl_i,
   input  logic                freeze_i,
   output logic [INST_W-1:0]   out_inst_o,
   output logic                out_issue_o,
   output logic                pc_hold_o,
   output logic [NUM_REGS-1:0] busy_vec_o
);

   localparam int CNT_W  = $clog2(WR_LAT + 1);
   localparam int CTRL_W = $clog2(CTRL_LAT + 1);

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] ld_q;
   logic [NUM_REGS-1:0] ld_d;
   logic [CTRL_W-1:0]   ctrl_cnt_q;
   logic [CTRL_W-1:0]   ctrl_cnt_d;

   logic [NUM_REGS-1:0] dep_vec;
   logic                haz_rs;
   logic                haz_rt;
   logic                block;
   logic                issue;

   // Per-register view of the scoreboard: which registers a reader must wait on,
   // and which have any write outstanding (the latter is reported unconditionally).
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
`ifdef HAZ_FWD_EN
         // With forwarding only a load issued last cycle cannot be bypassed.
         assign dep_vec[gi] = (cnt_q[gi] == CNT_W'(WR_LAT)) & ld_q[gi];
`else
         assign dep_vec[gi] = (cnt_q[gi] != '0);
`endif
         assign busy_vec_o[gi] = (cnt_q[gi] != '0);
      end
   endgenerate

   // Issue decision uses pre-update state, so an instruction never waits on its
   // own write, and rs==rt simply yields the same single hazard twice.
   always_comb begin
      haz_rs      = rs_en_i & dep_vec[rs_idx_i];
      haz_rt      = rt_en_i & dep_vec[rt_idx_i];
      block       = haz_rs | haz_rt | (ctrl_cnt_q != '0) | freeze_i;
      issue       = in_valid_i & ~block & ~rst_i;
      out_issue_o = issue;
      out_inst_o  = issue ? in_inst_i : NOP_INST;
      // A control op keeps PC held in its own issue cycle until it resolves.
      pc_hold_o   = ~issue | is_ctrl_i;
   end

   // Next-state: age all counters, then let a new issue reload its destination
   // (reload wins over decrement). Freeze holds everything.
   always_comb begin
      ld_d       = ld_q;
      ctrl_cnt_d = ctrl_cnt_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (!freeze_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
         end
         if (ctrl_cnt_q != '0) begin
            ctrl_cnt_d = ctrl_cnt_q - CTRL_W'(1);
         end
         if (issue && wr_en_i) begin
            cnt_d[wr_idx_i] = CNT_W'(WR_LAT);
            ld_d[wr_idx_i]  = wr_load_i;
         end
         if (issue && is_ctrl_i) begin
            ctrl_cnt_d = CTRL_W'(CTRL_LAT);
         end
      end
   end

   // Scoreboard state registers; reset drops every pending hazard at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
         ld_q       <= '0;
         ctrl_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         ld_q       <= ld_d;
         ctrl_cnt_q <= ctrl_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed per-cycle vectors, expected
// responses queued by the driver and checked by an independent monitor.
// Expectations follow the HAZ_FWD_EN setting of the build.
module tb_hazard_scoreboard;

   localparam logic [15:0] NOP = 16'h0800;
`ifdef HAZ_FWD_EN
   localparam int BUB_ALU = 0;
   localparam int BUB_LD  = 1;
   localparam int BUB_FRZ = 0;
`else
   localparam int BUB_ALU = 3;
   localparam int BUB_LD  = 3;
   localparam int BUB_FRZ = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_inst = 16'h0;
   logic        rs_en = 1'b0;
   logic [2:0]  rs_idx = 3'd0;
   logic        rt_en = 1'b0;
   logic [2:0]  rt_idx = 3'd0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_idx = 3'd0;
   logic        wr_load = 1'b0;
   logic        is_ctrl = 1'b0;
   logic        freeze = 1'b0;
   logic [15:0] out_inst;
   logic        out_issue;
   logic        pc_hold;
   logic [7:0]  busy_vec;

   typedef struct {
      logic        issue;
      logic [15:0] inst;
      logic        pch;
      logic [7:0]  busy;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   hazard_scoreboard dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_inst_i   (in_inst),
      .rs_en_i     (rs_en),
      .rs_idx_i    (rs_idx),
      .rt_en_i     (rt_en),
      .rt_idx_i    (rt_idx),
      .wr_en_i     (wr_en),
      .wr_idx_i    (wr_idx),
      .wr_load_i   (wr_load),
      .is_ctrl_i   (is_ctrl),
      .freeze_i    (freeze),
      .out_inst_o  (out_inst),
      .out_issue_o (out_issue),
      .pc_hold_o   (pc_hold),
      .busy_vec_o  (busy_vec)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if (out_issue !== e.issue || out_inst !== e.inst ||
             pc_hold !== e.pch || busy_vec !== e.busy) begin
            n_bad++;
            $display("FAIL %s: got issue=%0b inst=%h pc_hold=%0b busy=%h, want issue=%0b inst=%h pc_hold=%0b busy=%h",
                     e.name, out_issue, out_inst, pc_hold, busy_vec,
                     e.issue, e.inst, e.pch, e.busy);
         end else begin
            $display("ok   %s: issue=%0b inst=%h pc_hold=%0b busy=%h",
                     e.name, out_issue, out_inst, pc_hold, busy_vec);
         end
      end
   end

   task automatic drv(input logic v, input logic [15:0] inst,
                      input logic rse, input logic [2:0] rs,
                      input logic rte, input logic [2:0] rt,
                      input logic we, input logic [2:0] wi, input logic wl,
                      input logic c, input logic f);
      @(posedge clk);
      #1;
      in_valid = v;  in_inst = inst;
      rs_en = rse;   rs_idx = rs;
      rt_en = rte;   rt_idx = rt;
      wr_en = we;    wr_idx = wi;  wr_load = wl;
      is_ctrl = c;   freeze = f;
   endtask

   task automatic expect_out(input logic iss, input logic pch,
                             input logic [7:0] busy, input string nm);
      exp_t e;
      e.issue = iss;
      e.inst  = iss ? in_inst : NOP;
      e.pch   = pch;
      e.busy  = busy;
      e.name  = nm;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [7:0] busy, input string nm);
      drv(1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      expect_out(1'b0, 1'b1, busy, nm);
   endtask

   // Reader that sees cnt_now on its first cycle: bub stall cycles, one issue
   // cycle, then idle cycles until the producer's counter has drained.
   task automatic reader_seq(input int cnt_now, input int bub, input logic [7:0] mask,
                             input logic [15:0] inst,
                             input logic rse, input logic [2:0] rs,
                             input logic rte, input logic [2:0] rt,
                             input string nm);
      for (int k = 0; k < bub; k++) begin
         drv(1'b1, inst, rse, rs, rte, rt, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         expect_out(1'b0, 1'b1, mask, $sformatf("%s_stall%0d", nm, k));
      end
      drv(1'b1, inst, rse, rs, rte, rt, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, (cnt_now - bub > 0) ? mask : 8'h00, $sformatf("%s_issue", nm));
      for (int r = cnt_now - bub - 1; r > 0; r--) begin
         idle(mask, $sformatf("%s_drain%0d", nm, r));
      end
   endtask

   initial begin
      // Reset held: nothing issues, PC held, no pending writes.
      drv(1'b1, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
      expect_out(1'b0, 1'b1, 8'h00, "reset_hold");
      drv(1'b1, 16'h1235, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      expect_out(1'b1, 1'b0, 8'h00, "first_issue");

      // RAW on r3 from an ALU writer.
      drv(1'b1, 16'hA001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "wr_r3");
      reader_seq(3, BUB_ALU, 8'h08, 16'hA002, 1'b1, 3'd3, 1'b0, 3'd0, "rd_r3");

      // Load-use on r1 via rt, then ALU writer r1 and reader.
      drv(1'b1, 16'hA101, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "ld_r1");
      reader_seq(3, BUB_LD, 8'h02, 16'hA102, 1'b0, 3'd0, 1'b1, 3'd1, "rd_ld_r1");
      drv(1'b1, 16'hA103, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "alu_r1");
      reader_seq(3, BUB_ALU, 8'h02, 16'hA104, 1'b0, 3'd0, 1'b1, 3'd1, "rd_alu_r1");

      // WAW on r5 reloads the counter; reader uses rs==rt==r5.
      drv(1'b1, 16'hA003, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "waw_first");
      drv(1'b1, 16'hA004, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h20, "waw_second");
      reader_seq(3, BUB_ALU, 8'h20, 16'hA005, 1'b1, 3'd5, 1'b1, 3'd5, "rd_r5");

      // Self-dependence: reads and writes r6, issues; idle cycles age it.
      drv(1'b1, 16'hA006, 1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "self_dep");
      idle(8'h40, "age3");
      idle(8'h40, "age2");
      idle(8'h40, "age1");
      idle(8'h00, "age0");

      // Freeze with cnt[4]=2: state held for two cycles.
      drv(1'b1, 16'hA007, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "wr_r4");
      idle(8'h10, "r4_cnt3");
      drv(1'b1, 16'hA008, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      expect_out(1'b0, 1'b1, 8'h10, "freeze1");
      drv(1'b1, 16'hA008, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      expect_out(1'b0, 1'b1, 8'h10, "freeze2");
      reader_seq(2, BUB_FRZ, 8'h10, 16'hA009, 1'b1, 3'd4, 1'b0, 3'd0, "rd_r4");

      // Control op: PC held at issue, then four bubbles, then issue.
      drv(1'b1, 16'hB001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      expect_out(1'b1, 1'b1, 8'h00, "ctrl_issue");
      for (int k = 0; k < 4; k++) begin
         drv(1'b1, 16'hB002, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         expect_out(1'b0, 1'b1, 8'h00, $sformatf("ctrl_bubble%0d", k));
      end
      drv(1'b1, 16'hB002, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "after_ctrl");

      // Reset mid-stream with cnt[2]=3 drops the hazard immediately.
      drv(1'b1, 16'hC001, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      expect_out(1'b1, 1'b0, 8'h00, "wr_r2");
      drv(1'b1, 16'hC002, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      expect_out(1'b0, 1'b1, 8'h00, "mid_reset");
      drv(1'b1, 16'hC002, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      expect_out(1'b1, 1'b0, 8'h00, "post_reset_issue");

      // Let the monitor drain, bounded.
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
